// File: rtl/draw_square.sv
// draw_square: on start, writes a SIZE x SIZE block of one colour to the VGA
// adapter one pixel per clock in row-major order, clipping pixels that fall
// off the visible screen, then pulses done for one cycle.
module draw_square #(
    parameter int unsigned SIZE     = 2,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [17:0] colour,
    output logic        busy,
    output logic        done,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [17:0] vga_colour,
    output logic        vga_write
);

    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned C_W   = 18;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned XS_W  = X_W + 1;
    localparam int unsigned YS_W  = Y_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cx_q, cx_d;
    logic [CNT_W-1:0] cy_q, cy_d;
    logic [X_W-1:0]   bx_q, bx_d;
    logic [Y_W-1:0]   by_q, by_d;
    logic [C_W-1:0]   bc_q, bc_d;
    logic             done_q, done_d;
    logic             write_q, write_d;
    logic [X_W-1:0]   vx_q, vx_d;
    logic [Y_W-1:0]   vy_q, vy_d;
    logic [C_W-1:0]   vc_q, vc_d;

    logic [XS_W-1:0]  x_sum_c;
    logic [YS_W-1:0]  y_sum_c;
    logic             clip_c;
    logic             last_col_c;
    logic             last_row_c;

    // Pixel address with one guard bit so edge wrap is caught by the clip test
    always_comb begin
        x_sum_c    = XS_W'(bx_q) + XS_W'(cx_q);
        y_sum_c    = YS_W'(by_q) + YS_W'(cy_q);
        clip_c     = (x_sum_c >= XS_W'(SCREEN_W)) || (y_sum_c >= YS_W'(SCREEN_H));
        last_col_c = (cx_q == CNT_W'(SIZE - 1));
        last_row_c = (cy_q == CNT_W'(SIZE - 1));
    end

    // State and datapath registers; reset aborts any square in progress
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            bc_q    <= '0;
            done_q  <= 1'b0;
            write_q <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bc_q    <= bc_d;
            done_q  <= done_d;
            write_q <= write_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        bx_d    = bx_q;
        by_d    = by_q;
        bc_d    = bc_q;
        done_d  = 1'b0;
        write_d = 1'b0;
        vx_d    = vx_q;
        vy_d    = vy_q;
        vc_d    = vc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bx_d    = x;
                    by_d    = y;
                    bc_d    = colour;
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = S_DRAW;
                end
            end
            S_DRAW: begin
                vx_d    = x_sum_c[X_W-1:0];
                vy_d    = y_sum_c[Y_W-1:0];
                vc_d    = bc_q;
                write_d = ~clip_c;
                if (last_col_c) begin
                    cx_d = '0;
                    if (last_row_c) begin
                        cy_d    = '0;
                        state_d = S_FLUSH;
                    end else begin
                        cy_d = cy_q + CNT_W'(1);
                    end
                end else begin
                    cx_d = cx_q + CNT_W'(1);
                end
            end
            S_FLUSH: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign vga_write  = write_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;

endmodule

// File: tb/tb_draw_square.sv
// Bench for draw_square: three instances (SIZE 1, 2, 4) share one stimulus
// stream and are checked every cycle against a transaction-level model that
// tracks cycles since acceptance and derives each pixel from its index.
module tb_draw_square;

    localparam int NI = 3;
    localparam int SZ [NI] = '{1, 2, 4};

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [17:0] colour;

    logic [NI-1:0]        busy_w;
    logic [NI-1:0]        done_w;
    logic [NI-1:0]        wr_w;
    logic [NI-1:0][7:0]   vx_w;
    logic [NI-1:0][6:0]   vy_w;
    logic [NI-1:0][17:0]  vc_w;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // model state per instance
    bit          m_valid = 0;
    bit          m_act [NI];
    int          m_t   [NI];
    logic [7:0]  m_bx  [NI];
    logic [6:0]  m_by  [NI];
    logic [17:0] m_bc  [NI];
    logic [7:0]  m_vx  [NI];
    logic [6:0]  m_vy  [NI];
    logic [17:0] m_vc  [NI];

    draw_square #(.SIZE(1)) u_s1 (
        .clock(clock), .reset(reset), .start(start), .x(x), .y(y), .colour(colour),
        .busy(busy_w[0]), .done(done_w[0]), .vga_x(vx_w[0]), .vga_y(vy_w[0]),
        .vga_colour(vc_w[0]), .vga_write(wr_w[0])
    );

    draw_square #(.SIZE(2)) u_s2 (
        .clock(clock), .reset(reset), .start(start), .x(x), .y(y), .colour(colour),
        .busy(busy_w[1]), .done(done_w[1]), .vga_x(vx_w[1]), .vga_y(vy_w[1]),
        .vga_colour(vc_w[1]), .vga_write(wr_w[1])
    );

    draw_square #(.SIZE(4)) u_s4 (
        .clock(clock), .reset(reset), .start(start), .x(x), .y(y), .colour(colour),
        .busy(busy_w[2]), .done(done_w[2]), .vga_x(vx_w[2]), .vga_y(vy_w[2]),
        .vga_colour(vc_w[2]), .vga_write(wr_w[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // screen position of pixel k (row-major) of the square held by instance i
    task automatic pix(input int i, input int k, output int px, output int py);
        px = int'(m_bx[i]) + (k % SZ[i]);
        py = int'(m_by[i]) + (k / SZ[i]);
    endtask

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s size=%0d cycle=%0d observed=%0h expected=%0h", tag, SZ[i], cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        int n, px, py;
        bit e_busy, e_done, e_wr;
        if (!m_valid) return;
        for (int i = 0; i < NI; i++) begin
            n      = SZ[i] * SZ[i];
            e_busy = m_act[i];
            e_done = m_act[i] && (m_t[i] == n + 2);
            e_wr   = 1'b0;
            if (m_act[i] && m_t[i] >= 2 && m_t[i] <= n + 1) begin
                pix(i, m_t[i] - 2, px, py);
                e_wr = !(px >= 160 || py >= 120);
            end
            chk("busy",       i, 32'(busy_w[i]), 32'(e_busy));
            chk("done",       i, 32'(done_w[i]), 32'(e_done));
            chk("vga_write",  i, 32'(wr_w[i]),   32'(e_wr));
            chk("vga_x",      i, 32'(vx_w[i]),   32'(m_vx[i]));
            chk("vga_y",      i, 32'(vy_w[i]),   32'(m_vy[i]));
            chk("vga_colour", i, 32'(vc_w[i]),   32'(m_vc[i]));
        end
    endtask

    task automatic model_update(input logic st, input logic [7:0] xi, input logic [6:0] yi,
                                input logic [17:0] ci, input logic rs);
        int n, px, py;
        if (rs) m_valid = 1;
        for (int i = 0; i < NI; i++) begin
            n = SZ[i] * SZ[i];
            if (rs) begin
                m_act[i] = 0;
                m_t[i]   = 0;
                m_vx[i]  = '0;
                m_vy[i]  = '0;
                m_vc[i]  = '0;
            end else if (m_act[i]) begin
                if (m_t[i] == n + 2) begin
                    m_act[i] = 0;
                end else begin
                    m_t[i]++;
                    if (m_t[i] >= 2 && m_t[i] <= n + 1) begin
                        pix(i, m_t[i] - 2, px, py);
                        m_vx[i] = 8'(px);
                        m_vy[i] = 7'(py);
                        m_vc[i] = m_bc[i];
                    end
                end
            end else if (st) begin
                m_act[i] = 1;
                m_t[i]   = 1;
                m_bx[i]  = xi;
                m_by[i]  = yi;
                m_bc[i]  = ci;
            end
        end
    endtask

    // one clock: check outputs of this cycle, drive inputs, advance the model
    task automatic step(input logic st, input int xi, input int yi, input logic [17:0] ci, input logic rs);
        @(negedge clock);
        check_all();
        start  = st;
        x      = 8'(xi);
        y      = 7'(yi);
        colour = ci;
        reset  = rs;
        @(posedge clock);
        model_update(st, 8'(xi), 7'(yi), ci, rs);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 18'h0, 1'b0);
    endtask

    initial begin
        int rx, ry;
        logic rst_r, st_r;
        reset  = 1'b1;
        start  = 1'b0;
        x      = '0;
        y      = '0;
        colour = '0;

        step(1'b0, 0, 0, 18'h0, 1'b1);
        step(1'b0, 0, 0, 18'h0, 1'b1);
        idle(3);

        // basic square
        step(1'b1, 10, 20, 18'h3F000, 1'b0);
        idle(22);

        // bottom-right corner, only the corner pixel is visible
        step(1'b1, 159, 119, 18'h00FFF, 1'b0);
        idle(22);

        // x wrap at 255 must clip
        step(1'b1, 255, 0, 18'h12345, 1'b0);
        idle(22);

        // origin
        step(1'b1, 0, 0, 18'h2AAAA, 1'b0);
        idle(22);

        // start held high with inputs changing after the start cycle
        step(1'b1, 10, 20, 18'h3F000, 1'b0);
        for (int k = 0; k < 12; k++) step(1'b1, 50, 20, 18'h3F000, 1'b0);
        idle(22);

        // reset in cycle 3 aborts
        step(1'b1, 10, 20, 18'h3F000, 1'b0);
        idle(2);
        step(1'b0, 0, 0, 18'h0, 1'b1);
        idle(22);

        // larger square
        step(1'b1, 100, 50, 18'h15555, 1'b0);
        idle(22);

        // y wrap at 127 and far-right column
        step(1'b1, 157, 126, 18'h0F0F0, 1'b0);
        idle(22);

        // random traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            st_r  = ($urandom_range(0, 2) == 0);
            rst_r = ($urandom_range(0, 79) == 0);
            rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 255));
            ry = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 127));
            step(st_r, rx, ry, 18'($urandom), rst_r);
        end
        idle(25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/draw_square.md
Name: draw_square

Overview:
- Responder end of the start/done square-draw handshake used by the HUD and crosshair drawers.
- On `start`, latches a top-left pixel coordinate and a colour. It then writes a SIZE x SIZE block of pixels to the VGA adapter, one pixel per clock, in row-major order.
- Pixels outside the 160x120 screen are clipped.
- Pulses `done` for one cycle after the last write, so the initiator can sequence several squares back to back.

Parameters:
- SIZE, 2, side length of the square in pixels (1..16).
- SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- x  input  8  top-left pixel x; sampled with start
- y  input  7  top-left pixel y; sampled with start
- colour  input  18  pixel colour; sampled with start
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse, registered
- vga_x  output  8  pixel x to VGA adapter, registered
- vga_y  output  7  pixel y to VGA adapter, registered
- vga_colour  output  18  pixel colour, registered
- vga_write  output  1  write strobe, registered

Behaviour:
- Reset (clock is `clock`; reset is `reset`, synchronous, active-high):
  - state=IDLE; cx=cy=0.
  - done=0, vga_write=0, vga_x=0, vga_y=0, vga_colour=0.
  - Reset mid-operation aborts immediately: no further writes and no done pulse.
- States: IDLE, DRAW, FLUSH, DONE.
  - IDLE: if start=1, latch x, y, colour into bx, by, bc; clear cx, cy; go to DRAW. Otherwise stay in IDLE.
  - DRAW: each cycle produces pixel (bx+cx, by+cy).
    - cx increments every cycle. On cx==SIZE-1, cx wraps to 0 and cy increments.
    - On cx==SIZE-1 and cy==SIZE-1, go to FLUSH.
    - DRAW lasts exactly N=SIZE*SIZE cycles.
  - FLUSH: a single cycle in which the registered outputs present the final pixel; then go to DONE.
  - DONE: done=1 for exactly one cycle; vga_write=0; then go to IDLE.
- Output registers:
  - At each DRAW clock edge: vga_x<=bx+cx[7:0], vga_y<=by+cy[6:0], vga_colour<=bc, vga_write<=~clip.
  - Outside DRAW: vga_write<=0; vga_x, vga_y and vga_colour hold their last values.
- Clipping:
  - Sums are formed at 9 bits (x) and 8 bits (y).
  - clip=1 if the x sum >= SCREEN_W or the y sum >= SCREEN_H. This covers both off-screen and 8/7-bit wrap (e.g. x=255+1), so no wrapped pixel is ever written.
  - A clipped pixel still consumes its cycle. Total timing is independent of clipping.
- Timing, with cycle 0 = the IDLE cycle where start=1:
  - vga_write is high (unless clipped) in cycles 2..N+1, for pixel k in cycle k+2.
  - done=1 in cycle N+2.
  - start is next accepted in cycle N+3.
- start while busy (DRAW, FLUSH or DONE) is ignored. It is not queued, and inputs are not re-sampled.
- x, y and colour may change freely after the start cycle; the latched copies are used.
- busy is combinational from state. done is registered and never high together with vga_write.

Test Plan:
- SIZE=2, start with x=10, y=20, colour=18'h3F000 -> writes (10,20), (11,20), (10,21), (11,21) in cycles 2-5 with vga_colour=18'h3F000; done=1 only in cycle 6; busy=1 in cycles 1-6.
- SIZE=2, x=159, y=119 -> only (159,119) is written, in cycle 2; vga_write=0 in cycles 3-5; done still in cycle 6. Also x=255, y=0 -> pixel (255,0) is clipped, so no write occurs in any cycle; done in cycle 6.
- SIZE=1, x=0, y=0 -> a single write of (0,0) in cycle 2; done in cycle 3; a new start in cycle 4 is accepted.
- SIZE=2 from the first scenario, start held high continuously with x changed to 50 in cycle 1 -> pixels 10..11 unaffected; second square begins from IDLE in cycle 7 with x=50, first write in cycle 9.
- SIZE=2 from the first scenario, reset asserted in cycle 3 -> from cycle 4 on: vga_write=0, vga_x=vga_y=vga_colour=0, done never pulses, busy=0; next start behaves as from power-on.
- SIZE=4, x=100, y=50 -> 16 writes in cycles 2-17, raster order (100..103, 50) through (100..103, 53); done in cycle 18.
